sobel_pipe: RTL

Pipelined, parametrised successor of the combinational Sobel core. It accepts one 3x3 pixel window per beat over a valid/ready handshake and computes the X and Y Sobel gradients. It emits one edge pixel per beat in a run-time-selectable mode: L1 magnitude, |Gx|, |Gy| or binary threshold. Output scaling and saturation are configurable. The block sits between the window/line-buffer stage and the output pixel packer, and sustains one window per clock.

---
 rtl/sobel_pipe_if.sv | 26 ++
 rtl/sobel_pipe.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sobel_pipe_if.sv
// Window-in / pixel-out handshake bundle for sobel_pipe.
// master: the surrounding datapath (line buffer upstream, pixel packer downstream).
// slave: the Sobel core itself.
interface sobel_pipe_if #(
  parameter int unsigned PIXEL_W = 8,
  parameter int unsigned OUT_W   = 8
);
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [9*PIXEL_W-1:0]   win_i;
  logic [1:0]             mode_i;
  logic [PIXEL_W+2:0]     thr_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [OUT_W-1:0]       pix_o;

  modport master (
    output in_valid_i, win_i, mode_i, thr_i, out_ready_i,
    input  in_ready_o, out_valid_o, pix_o
  );

  modport slave (
    input  in_valid_i, win_i, mode_i, thr_i, out_ready_i,
    output in_ready_o, out_valid_o, pix_o
  );
endinterface

// File: rtl/sobel_pipe.sv
// sobel_pipe: three-stage pipelined 3x3 Sobel edge detector.
// S1 registers the column/row differences, S2 the gradient magnitudes, S3 the final pixel.
// Each stage has its own valid bit and loads whenever it is empty or its successor drains.
module sobel_pipe #(
  parameter int unsigned PIXEL_W = 8,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned SHIFT   = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  sobel_pipe_if.slave      bus,
  input  logic             clr_cnt_i,
  output logic [CNT_W-1:0] sat_cnt_o
);

  localparam int unsigned GW = PIXEL_W + 3;
  localparam int unsigned CW = (GW > OUT_W) ? GW : OUT_W;
  localparam logic [CW-1:0] OutMax = CW'((65'd1 << OUT_W) - 65'd1);

  localparam logic [1:0] ModeGx  = 2'd1;
  localparam logic [1:0] ModeGy  = 2'd2;
  localparam logic [1:0] ModeThr = 2'd3;

  // a - b, sign-extended to the gradient width
  function automatic logic signed [GW-1:0] diff(input logic [PIXEL_W-1:0] a,
                                                 input logic [PIXEL_W-1:0] b);
    return $signed({3'b000, a}) - $signed({3'b000, b});
  endfunction

  // 2*(a - b) for the centre row/column taps
  function automatic logic signed [GW-1:0] diff2(input logic [PIXEL_W-1:0] a,
                                                  input logic [PIXEL_W-1:0] b);
    return $signed({2'b00, a, 1'b0}) - $signed({2'b00, b, 1'b0});
  endfunction

  // Window taps; the centre pixel has zero weight in both kernels.
  logic [PIXEL_W-1:0] p00, p01, p02, p10, p12, p20, p21, p22;
  logic               unused_centre;

  assign p00 = bus.win_i[0*PIXEL_W +: PIXEL_W];
  assign p01 = bus.win_i[1*PIXEL_W +: PIXEL_W];
  assign p02 = bus.win_i[2*PIXEL_W +: PIXEL_W];
  assign p10 = bus.win_i[3*PIXEL_W +: PIXEL_W];
  assign p12 = bus.win_i[5*PIXEL_W +: PIXEL_W];
  assign p20 = bus.win_i[6*PIXEL_W +: PIXEL_W];
  assign p21 = bus.win_i[7*PIXEL_W +: PIXEL_W];
  assign p22 = bus.win_i[8*PIXEL_W +: PIXEL_W];
  assign unused_centre = ^bus.win_i[4*PIXEL_W +: PIXEL_W];

  // Stage state
  logic                 v1_q, v2_q, v3_q;
  logic signed [GW-1:0] dx_q [3];
  logic signed [GW-1:0] dy_q [3];
  logic [1:0]           mode1_q, mode2_q;
  logic [GW-1:0]        thr1_q, thr2_q;
  logic [GW-1:0]        ax_q, ay_q;
  logic [OUT_W-1:0]     pix_q;
  logic                 sat3_q;
  logic [CNT_W-1:0]     sat_cnt_q;

  // Per-stage ready: a stage can take a beat if it is empty or its contents move on.
  logic rdy1, rdy2, rdy3;
  assign rdy3 = !v3_q || bus.out_ready_i;
  assign rdy2 = !v2_q || rdy3;
  assign rdy1 = !v1_q || rdy2;

  assign bus.in_ready_o  = rdy1;
  assign bus.out_valid_o = v3_q;
  assign bus.pix_o       = pix_q;
  assign sat_cnt_o       = sat_cnt_q;

  // S1 next state: pairwise differences with centre taps doubled
  logic signed [GW-1:0] dx_d [3];
  logic signed [GW-1:0] dy_d [3];
  always_comb begin
    dx_d[0] = diff(p02, p00);
    dx_d[1] = diff2(p12, p10);
    dx_d[2] = diff(p22, p20);
    dy_d[0] = diff(p20, p00);
    dy_d[1] = diff2(p21, p01);
    dy_d[2] = diff(p22, p02);
  end

  // S2 next state: gradients and their exact absolute values
  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]        ax_d, ay_d;
  always_comb begin
    gx   = dx_q[0] + dx_q[1] + dx_q[2];
    gy   = dy_q[0] + dy_q[1] + dy_q[2];
    ax_d = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
    ay_d = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
  end

  // S3 next state: mode select, scale, saturate or threshold
  logic [GW-1:0]    sum, mag, scaled;
  logic [CW-1:0]    scaled_ext;
  logic [OUT_W-1:0] pix_d;
  logic             sat_d;
  always_comb begin
    sum = ax_q + ay_q;
    case (mode2_q)
      ModeGx:  mag = ax_q;
      ModeGy:  mag = ay_q;
      default: mag = sum;
    endcase
    scaled     = mag >> SHIFT;
    scaled_ext = CW'(scaled);
    pix_d      = '0;
    sat_d      = 1'b0;
    if (mode2_q == ModeThr) begin
      // threshold compares the raw sum, never flagged as saturation
      pix_d = (sum >= thr2_q) ? '1 : '0;
    end else if (scaled_ext > OutMax) begin
      pix_d = '1;
      sat_d = 1'b1;
    end else begin
      pix_d = OUT_W'(scaled_ext);
    end
  end

  // Valid bits and the output register; reset discards everything in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      pix_q  <= '0;
      sat3_q <= 1'b0;
    end else begin
      if (rdy1) v1_q <= bus.in_valid_i;
      if (rdy2) v2_q <= v1_q;
      if (rdy3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          pix_q  <= pix_d;
          sat3_q <= sat_d;
        end
      end
    end
  end

  // Payload registers of S1/S2; mode and threshold travel with their beat.
  always_ff @(posedge clk_i) begin
    if (rdy1 && bus.in_valid_i) begin
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      mode1_q <= bus.mode_i;
      thr1_q  <= bus.thr_i;
    end
    if (rdy2 && v1_q) begin
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      mode2_q <= mode1_q;
      thr2_q  <= thr1_q;
    end
  end

  // Saturation counter: counts delivered saturated pixels, sticks at max, clear wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sat_cnt_q <= '0;
    end else if (clr_cnt_i) begin
      sat_cnt_q <= '0;
    end else if (v3_q && bus.out_ready_i && sat3_q && !(&sat_cnt_q)) begin
      sat_cnt_q <= sat_cnt_q + CNT_W'(1);
    end
  end

endmodule
